// File: rtl/lz77_pkg.sv
// Shared LZ77 defaults and the decoder state encoding.
// Keep these values in step with the encoder's configuration.
package lz77_pkg;

  localparam int DATA_WIDTH           = 8;
  localparam int DICTIONARY_DEPTH     = 16;
  localparam int DICTIONARY_DEPTH_LOG = 4;
  localparam int CNT_WIDTH            = 3;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    LIT
  } lz77_dec_state_t;

endpackage

// File: rtl/lz77_history_buf.sv
// History dictionary: a shift register (entry 0 newest) with an asynchronous
// clear and a combinational read tap at rd_addr.
module lz77_history_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] taps [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;
      logic [DATA_WIDTH-1:0] entry_src;

      if (gi == 0) begin : g_head
        assign entry_src = data_in;
      end else begin : g_tail
        assign entry_src = taps[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (shift_en) begin
          entry_reg <= entry_src;
        end
      end

      assign taps[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = taps[rd_addr];

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: each token yields match_length copied bytes then a literal.
// Define LZ77_DEC_BACK2BACK_EN to accept the next token during the literal beat.
module lz77_decoder #(
  parameter int DATA_WIDTH           = lz77_pkg::DATA_WIDTH,
  parameter int DICTIONARY_DEPTH     = lz77_pkg::DICTIONARY_DEPTH,
  parameter int DICTIONARY_DEPTH_LOG = lz77_pkg::DICTIONARY_DEPTH_LOG,
  parameter int CNT_WIDTH            = lz77_pkg::CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DICTIONARY_DEPTH_LOG-1:0] match_position,
  input  logic [CNT_WIDTH-1:0]            match_length,
  input  logic [DATA_WIDTH-1:0]           next_symbol,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            busy
);

  import lz77_pkg::*;

  lz77_dec_state_t                 state_reg, state_next;
  logic [DICTIONARY_DEPTH_LOG-1:0] pos_reg, pos_next;
  logic [CNT_WIDTH-1:0]            cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]           sym_reg, sym_next;
  logic                            shift_en;
  logic                            load;
  logic [DATA_WIDTH-1:0]           hist_data;

  // Every emitted byte is pushed back into history, so pos_reg stays fixed
  // while the shift walks the source forward (overlapping runs just work).
  lz77_history_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DICTIONARY_DEPTH),
    .ADDR_WIDTH (DICTIONARY_DEPTH_LOG)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .data_in  (out_data),
    .rd_addr  (pos_reg),
    .rd_data  (hist_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pos_reg   <= '0;
      cnt_reg   <= '0;
      sym_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      cnt_reg   <= cnt_next;
      sym_reg   <= sym_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    cnt_next   = cnt_reg;
    sym_next   = sym_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    shift_en   = 1'b0;
    load       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      COPY: begin
        out_valid = 1'b1;
        out_data  = hist_data;
        if (out_ready) begin
          shift_en = 1'b1;
          cnt_next = cnt_reg - CNT_WIDTH'(1);
          if (cnt_reg == CNT_WIDTH'(1)) begin
            state_next = LIT;
          end
        end
      end
      LIT: begin
        out_valid = 1'b1;
        out_data  = sym_reg;
`ifdef LZ77_DEC_BACK2BACK_EN
        in_ready  = out_ready;
        load      = out_ready && in_valid;
`endif
        if (out_ready) begin
          shift_en   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new token overrides the literal's return to IDLE when chained.
    if (load) begin
      pos_next   = match_position;
      cnt_next   = match_length;
      sym_next   = next_symbol;
      state_next = (match_length != '0) ? COPY : LIT;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
